// File: rtl/vol_flag_poller_if.sv
// Avalon-MM read bus between the flag poller and the PIO slave.
// The address is driven constant by the master; the slave answers with readdata.
interface vol_flag_poller_if;

  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );

endinterface

// File: rtl/vol_flag_poller.sv
// Periodic Avalon-MM poller of a 1-bit PIO flag with debounce and edge pulses.
// Define VOL_FLAG_POLLER_IRQ_EN to add a sticky irq output with irq_ack.
module vol_flag_poller #(
  parameter int unsigned POLL_DIV     = 50000,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STABLE_N     = 3,
  parameter logic [1:0]  POLL_ADDR    = 2'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  vol_flag_poller_if.master avm,
  output logic        vol_flag,
  output logic        vol_flag_rise,
  output logic        vol_flag_fall,
  output logic        busy,
  output logic [15:0] sample_cnt
`ifdef VOL_FLAG_POLLER_IRQ_EN
  ,
  output logic        irq,
  input  logic        irq_ack
`endif
);

  localparam int PW = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;

  // Full idle wait after reset or while disabled.
  localparam logic [PW-1:0] RELOAD = PW'(POLL_DIV - 1);

  // After a capture the CAPT cycle is already the
  // first cycle of the next poll period.
  localparam logic [PW-1:0] RELOAD_C = PW'(POLL_DIV - 2);

  localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);
  localparam logic [3:0] STAB     = 4'(STABLE_N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CAPT
  } state_t;

  state_t        state;
  logic [PW-1:0] poll_cnt;
  logic [1:0]    lat_cnt;
  logic          smp;
  logic [3:0]    stab;
  logic          cand;

  logic [3:0]    stab_nxt;
  logic [3:0]    run_len;
  logic          cand_nxt;
  logic          flip;

  logic          unused_rd;

  assign avm.avm_address = POLL_ADDR;
  assign unused_rd       = ^avm.avm_readdata[31:1];

  // Debounce decision for the sample held in smp.
  always_comb begin
    stab_nxt = stab;
    cand_nxt = cand;
    run_len  = 4'd0;
    flip     = 1'b0;
    if (smp == vol_flag) begin
      stab_nxt = 4'd0;
    end else begin
      if (smp == cand) begin
        run_len = stab + 4'd1;
      end else begin
        cand_nxt = smp;
        run_len  = 4'd1;
      end
      if (run_len == STAB) begin
        flip     = 1'b1;
        stab_nxt = 4'd0;
      end else begin
        stab_nxt = run_len;
      end
    end
  end

  // Poll sequencer, capture, debounce and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      poll_cnt      <= RELOAD;
      lat_cnt       <= 2'd0;
      smp           <= 1'b0;
      stab          <= 4'd0;
      cand          <= 1'b0;
      avm.avm_read  <= 1'b0;
      busy          <= 1'b0;
      vol_flag      <= 1'b0;
      vol_flag_rise <= 1'b0;
      vol_flag_fall <= 1'b0;
      sample_cnt    <= 16'd0;
    end else begin
      vol_flag_rise <= 1'b0;
      vol_flag_fall <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!enable) begin
            poll_cnt <= RELOAD;
          end else if (poll_cnt == '0) begin
            state        <= S_REQ;
            avm.avm_read <= 1'b1;
            busy         <= 1'b1;
          end else begin
            poll_cnt <= poll_cnt - 1'b1;
          end
        end
        S_REQ: begin
          if (!avm.avm_waitrequest) begin
            state        <= S_WAIT;
            avm.avm_read <= 1'b0;
            lat_cnt      <= LAT_INIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == 2'd0) begin
            state <= S_CAPT;
            busy  <= 1'b0;
            smp   <= avm.avm_readdata[0];
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        S_CAPT: begin
          state      <= S_IDLE;
          poll_cnt   <= RELOAD_C;
          sample_cnt <= sample_cnt + 16'd1;
          stab       <= stab_nxt;
          cand       <= cand_nxt;
          if (flip) begin
            vol_flag      <= smp;
            vol_flag_rise <= smp;
            vol_flag_fall <= ~smp;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef VOL_FLAG_POLLER_IRQ_EN
  // Sticky edge interrupt; a new edge wins over ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= ((state == S_CAPT) && flip) | (irq & ~irq_ack);
    end
  end
`endif

endmodule

// File: tb/tb_vol_flag_poller.sv
// Directed bench for vol_flag_poller: a 1-cycle and a 3-cycle latency
// instance, each with a PIO slave model that drives valid data only at A+RL.
module tb_vol_flag_poller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, enable, reset_b, enable_b;
  logic wr_a;
  logic [31:0] word_a, word_b;
  int lat_a = 0;
  int lat_b = 0;

  vol_flag_poller_if ifa ();
  vol_flag_poller_if ifb ();

  logic vf, rise, fall, busy;
  logic [15:0] scnt;
  logic vf_b, rise_b, fall_b, busy_b;
  logic [15:0] scnt_b;

`ifdef VOL_FLAG_POLLER_IRQ_EN
  logic irq, irq_ack, irq_b;
  logic irq_ack_b = 1'b0;
  bit ack_in_capt = 1'b0;
`endif

  // Slave models: readdata is valid only READ_LATENCY cycles after acceptance.
  always @(posedge clk) begin
    if (ifa.avm_read && !ifa.avm_waitrequest) lat_a <= 1;
    else if (lat_a > 0) lat_a <= lat_a - 1;
  end
  always @(posedge clk) begin
    if (ifb.avm_read && !ifb.avm_waitrequest) lat_b <= 3;
    else if (lat_b > 0) lat_b <= lat_b - 1;
  end

  assign ifa.avm_waitrequest = wr_a;
  assign ifa.avm_readdata = (lat_a == 1) ? word_a : ~word_a;
  assign ifb.avm_waitrequest = 1'b0;
  assign ifb.avm_readdata = (lat_b == 1) ? word_b : ~word_b;

  vol_flag_poller #(
    .POLL_DIV(4), .READ_LATENCY(1), .STABLE_N(3), .POLL_ADDR(2'd2)
  ) u_a (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .avm(ifa),
    .vol_flag(vf),
    .vol_flag_rise(rise),
    .vol_flag_fall(fall),
    .busy(busy),
    .sample_cnt(scnt)
`ifdef VOL_FLAG_POLLER_IRQ_EN
    ,
    .irq(irq),
    .irq_ack(irq_ack)
`endif
  );

  vol_flag_poller #(
    .POLL_DIV(4), .READ_LATENCY(3), .STABLE_N(1), .POLL_ADDR(2'd1)
  ) u_b (
    .clk(clk),
    .reset(reset_b),
    .enable(enable_b),
    .avm(ifb),
    .vol_flag(vf_b),
    .vol_flag_rise(rise_b),
    .vol_flag_fall(fall_b),
    .busy(busy_b),
    .sample_cnt(scnt_b)
`ifdef VOL_FLAG_POLLER_IRQ_EN
    ,
    .irq(irq_b),
    .irq_ack(irq_ack_b)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ifa.avm_read && n < 60);
  endtask

  task automatic wait_b(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ifb.avm_read && n < 60);
  endtask

  // One poll on instance A; returns in the cycle after CAPT.
  task automatic poll_a(input logic [31:0] w, output int n);
    word_a = w;
    wait_a(n);
    tick();
    tick();
`ifdef VOL_FLAG_POLLER_IRQ_EN
    irq_ack = ack_in_capt;
`endif
    tick();
`ifdef VOL_FLAG_POLLER_IRQ_EN
    irq_ack = 1'b0;
`endif
  endtask

  logic [31:0] glitch [6];
  int n;
  int reads;
  logic [15:0] s0;

  initial begin
    glitch = '{32'd1, 32'd1, 32'd0, 32'd1, 32'd1, 32'd1};
    reset = 1'b1;
    reset_b = 1'b1;
    enable = 1'b0;
    enable_b = 1'b0;
    wr_a = 1'b0;
    word_a = 32'd0;
    word_b = 32'd0;
`ifdef VOL_FLAG_POLLER_IRQ_EN
    irq_ack = 1'b0;
`endif
    repeat (3) tick();

    chk("rst_read", 32'(ifa.avm_read), 0);
    chk("rst_addr", 32'(ifa.avm_address), 2);
    chk("rst_flag", 32'(vf), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(scnt), 0);

    reset = 1'b0;
    reset_b = 1'b0;
    enable = 1'b1;

    word_a = 32'd1;
    wait_a(n);
    chk("first_read_lat", 32'(n), 4);
    chk("busy_req", 32'(busy), 1);
    tick();
    chk("read_one_cycle", 32'(ifa.avm_read), 0);
    chk("busy_wait", 32'(busy), 1);
    tick();
    chk("busy_capt", 32'(busy), 0);
    chk("cnt_before_capt", 32'(scnt), 0);
    tick();
    chk("cnt_1", 32'(scnt), 1);
    chk("flag_p1", 32'(vf), 0);

    // read-to-read period 6 = 3 poll cycles + 3 idle cycles
    poll_a(32'd1, n);
    chk("poll_period", 32'(n), 3);
    chk("cnt_2", 32'(scnt), 2);
    chk("flag_p2", 32'(vf), 0);

    poll_a(32'd1, n);
    chk("cnt_3", 32'(scnt), 3);
    chk("flag_p3", 32'(vf), 1);
    chk("rise_p3", 32'(rise), 1);
    chk("fall_p3", 32'(fall), 0);
`ifdef VOL_FLAG_POLLER_IRQ_EN
    chk("irq_set", 32'(irq), 1);
`endif
    tick();
    chk("rise_one_cycle", 32'(rise), 0);
    chk("flag_hold", 32'(vf), 1);
`ifdef VOL_FLAG_POLLER_IRQ_EN
    tick();
    chk("irq_sticky", 32'(irq), 1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("irq_ack_clr", 32'(irq), 0);
`endif

    poll_a(32'hFFFF_FFFE, n);
    poll_a(32'hFFFF_FFFE, n);
    chk("fall_hold", 32'(vf), 1);
`ifdef VOL_FLAG_POLLER_IRQ_EN
    ack_in_capt = 1'b1;
`endif
    poll_a(32'hFFFF_FFFE, n);
`ifdef VOL_FLAG_POLLER_IRQ_EN
    ack_in_capt = 1'b0;
    chk("irq_set_wins", 32'(irq), 1);
`endif
    chk("fall_flag", 32'(vf), 0);
    chk("fall_pulse", 32'(fall), 1);
    chk("fall_no_rise", 32'(rise), 0);

    for (int i = 0; i < 6; i++) begin
      poll_a(glitch[i], n);
      if (i == 2) chk("glitch_nofall", 32'(fall), 0);
      if (i == 4) chk("glitch_hold", 32'(vf), 0);
    end
    chk("glitch_flag", 32'(vf), 1);
    chk("glitch_rise", 32'(rise), 1);
    chk("glitch_fall", 32'(fall), 0);

    word_a = 32'd1;
    wr_a = 1'b1;
    wait_a(n);
    s0 = scnt;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wr_read_held", 32'(ifa.avm_read), 1);
      chk("wr_addr_held", 32'(ifa.avm_address), 2);
    end
    wr_a = 1'b0;
    tick();
    chk("wr_accept", 32'(ifa.avm_read), 0);
    tick();
    tick();
    chk("wr_capt", 32'(scnt), 32'(s0 + 16'd1));

    word_a = 32'd1;
    wait_a(n);
    tick();
    enable = 1'b0;
    s0 = scnt;
    tick();
    tick();
    chk("drain_capt", 32'(scnt), 32'(s0 + 16'd1));
    reads = 0;
    repeat (20) begin
      tick();
      if (ifa.avm_read) reads++;
    end
    chk("no_read_disabled", 32'(reads), 0);
    enable = 1'b1;
    wait_a(n);
    chk("reenable_lat", 32'(n), 4);

    chk("pre_rst_flag", 32'(vf), 1);
    reset = 1'b1;
    tick();
    chk("rreq_read", 32'(ifa.avm_read), 0);
    chk("rreq_busy", 32'(busy), 0);
    chk("rreq_flag", 32'(vf), 0);
    chk("rreq_cnt", 32'(scnt), 0);
    chk("rreq_edges", 32'({rise, fall}), 0);
`ifdef VOL_FLAG_POLLER_IRQ_EN
    chk("rreq_irq", 32'(irq), 0);
`endif
    reset = 1'b0;

    word_b = 32'd1;
    enable_b = 1'b1;
    wait_b(n);
    chk("rl3_first_lat", 32'(n), 4);
    chk("rl3_addr", 32'(ifb.avm_address), 1);
    repeat (5) tick();
    chk("rl3_capture", 32'(vf_b), 1);
    chk("rl3_rise", 32'(rise_b), 1);
    chk("rl3_cnt", 32'(scnt_b), 1);
`ifdef VOL_FLAG_POLLER_IRQ_EN
    chk("rl3_irq", 32'(irq_b), 1);
`endif
    // period 8 = 5 poll cycles + 3 idle cycles
    wait_b(n);
    chk("rl3_period", 32'(n), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
